// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver on system_clk: frame check (start, 8 data LSB first, odd parity, stop, timeout) into a byte FIFO.
// Byte readable one cycle after stop-bit fall (3 cycles after pin edge); full FIFO drops the byte and sets overflow.
module ps2_rx_fifo #(
    parameter int                    ADDR_WIDTH      = 14,
    parameter int                    DATA_WIDTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] DATA_ADDRESS    = 14'h3fff,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDRESS  = 14'h3ffe,
    parameter int                    FIFO_DEPTH_LOG2 = 6,
    parameter int                    TIMEOUT_CYCLES  = 100000
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  PS2_clk,
    input  logic                  PS2_data,
    input  logic                  read_character,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  irq
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    state_t            state, state_nxt;
    logic [2:0]        bitcnt, bitcnt_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              parity_bit, parity_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic              timed_out;
    logic              push, set_perr, set_ferr;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0]           count;
    logic                       empty, full, pop, wr_en, set_ovf, clr_err;
    logic                       parity_err, frame_err, overflow;

    // Idle-high lines, so sync flops reset to 1 to avoid a spurious fall after reset.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall      = clk_prev & ~clk_s2;
    assign timed_out = (state != ST_IDLE) && !fall && (to_cnt >= TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shift_nxt  = shift;
        parity_nxt = parity_bit;
        push       = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        if (timed_out) begin
            state_nxt = ST_IDLE;
            set_ferr  = 1'b1;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!dat_s2) begin
                        state_nxt  = ST_DATA;
                        bitcnt_nxt = 3'd0;
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_nxt[bitcnt] = dat_s2;
                    bitcnt_nxt        = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_nxt = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_nxt = dat_s2;
                    state_nxt  = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    set_ferr  = !dat_s2;
                    set_perr  = !(^shift ^ parity_bit);
                    push      = dat_s2 && (^shift ^ parity_bit);
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bitcnt     <= 3'd0;
            shift      <= 8'd0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bitcnt_nxt;
            shift      <= shift_nxt;
            parity_bit <= parity_nxt;
            if (fall || state == ST_IDLE) to_cnt <= '0;
            else                          to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = read_character && (address == DATA_ADDRESS) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en   = push && (!full || pop);
    assign set_ovf = push && full && !pop;
    assign clr_err = read_character && (address == STATUS_ADDRESS);

    always_ff @(posedge system_clk) begin
        if (wr_en) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            parity_err <= set_perr | (parity_err & ~clr_err);
            frame_err  <= set_ferr | (frame_err  & ~clr_err);
            overflow   <= set_ovf  | (overflow   & ~clr_err);
            irq        <= !empty;
        end
    end

    always_comb begin
        data = '0;
        if (address == DATA_ADDRESS) begin
            if (!empty) data[7:0] = mem[rd_ptr];
        end else if (address == STATUS_ADDRESS) begin
            data[15:0] = 16'(count);
            data[16]   = empty;
            data[17]   = full;
            data[18]   = parity_err;
            data[19]   = frame_err;
            data[20]   = overflow;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus random frames checked against a queue-based model.
module tb_ps2_rx_fifo;

    localparam int          LOG2 = 2;
    localparam int          DEPTH = 1 << LOG2;
    localparam int          HALF = 20;
    localparam logic [13:0] DA = 14'h3fff;
    localparam logic [13:0] SA = 14'h3ffe;

    logic        system_clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] address = SA;
    logic        PS2_clk = 1'b1;
    logic        PS2_data = 1'b1;
    logic        read_character = 1'b0;
    logic [63:0] data;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] model_q[$];
    bit         m_perr, m_ferr, m_ovf;

    ps2_rx_fifo #(
        .ADDR_WIDTH(14), .DATA_WIDTH(64), .DATA_ADDRESS(DA), .STATUS_ADDRESS(SA),
        .FIFO_DEPTH_LOG2(LOG2), .TIMEOUT_CYCLES(1000)
    ) dut (
        .system_clk(system_clk), .reset(reset), .address(address),
        .PS2_clk(PS2_clk), .PS2_data(PS2_data), .read_character(read_character),
        .data(data), .irq(irq)
    );

    always #5 system_clk = ~system_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    function automatic logic [63:0] exp_status();
        logic [63:0] s;
        s        = '0;
        s[15:0]  = 16'(model_q.size());
        s[16]    = (model_q.size() == 0);
        s[17]    = (model_q.size() == DEPTH);
        s[18]    = m_perr;
        s[19]    = m_ferr;
        s[20]    = m_ovf;
        return s;
    endfunction

    function automatic logic [63:0] exp_head();
        return (model_q.size() == 0) ? 64'd0 : {56'd0, model_q[0]};
    endfunction

    // kind: 0 good, 1 bad parity, 2 bad stop
    function automatic void model_frame(input logic [7:0] b, input int kind);
        if (kind == 1)                  m_perr = 1'b1;
        else if (kind == 2)             m_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else                            m_ovf = 1'b1;
    endfunction

    function automatic void model_pop();
        if (model_q.size() > 0) void'(model_q.pop_front());
    endfunction

    task automatic rd(input logic [13:0] a, output logic [63:0] v);
        address = a;
        #1;
        v = data;
    endtask

    task automatic do_pop();
        address = DA;
        read_character = 1'b1;
        @(negedge system_clk);
        read_character = 1'b0;
    endtask

    task automatic do_clear();
        address = SA;
        read_character = 1'b1;
        @(negedge system_clk);
        read_character = 1'b0;
        m_perr = 0; m_ferr = 0; m_ovf = 0;
    endtask

    // pop_at_fall strobes a pop on the cycle the DUT processes this bit's falling edge
    task automatic ps2_bit(input bit b, input bit pop_at_fall);
        PS2_data = b;
        repeat (HALF) @(negedge system_clk);
        PS2_clk = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge system_clk);
            if (pop_at_fall && i == 1) begin
                address = DA;
                read_character = 1'b1;
            end else if (pop_at_fall && i == 2) begin
                read_character = 1'b0;
            end
        end
        PS2_clk = 1'b1;
    endtask

    task automatic ps2_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit pop_on_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(!bad_stop, pop_on_stop);
        PS2_data = 1'b1;
        repeat (HALF) @(negedge system_clk);
    endtask

    task automatic test_reset();
        logic [63:0] v;
        rd(SA, v);
        tests_run++;
        if (v !== 64'h10000) begin $display("FAIL reset_status: got %h expected %h", v, 64'h10000); tests_failed++; end
        rd(DA, v);
        tests_run++;
        if (v !== 64'd0) begin $display("FAIL reset_data: got %h expected 0", v); tests_failed++; end
        tests_run++;
        if (irq !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", irq); tests_failed++; end
        @(negedge system_clk);
        reset = 1'b1;
        repeat (3) @(negedge system_clk);
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL post_reset_status: got %h expected %h", v, exp_status()); tests_failed++; end
    endtask

    task automatic test_single_frame();
        logic [63:0] v;
        ps2_frame(8'h1C, 0, 0, 0);
        model_frame(8'h1C, 0);
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL single_status: got %h expected %h", v, exp_status()); tests_failed++; end
        rd(DA, v);
        tests_run++;
        if (v !== 64'h1C) begin $display("FAIL single_data: got %h expected 1c", v); tests_failed++; end
        tests_run++;
        if (irq !== 1'b1) begin $display("FAIL single_irq: got %b expected 1", irq); tests_failed++; end
        do_pop();
        model_pop();
        rd(DA, v);
        tests_run++;
        if (v !== 64'd0) begin $display("FAIL pop_data: got %h expected 0", v); tests_failed++; end
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL pop_status: got %h expected %h", v, exp_status()); tests_failed++; end
        tests_run++;
        if (irq !== 1'b1) begin $display("FAIL irq_lag: got %b expected 1", irq); tests_failed++; end
        @(negedge system_clk);
        tests_run++;
        if (irq !== 1'b0) begin $display("FAIL irq_clear: got %b expected 0", irq); tests_failed++; end
    endtask

    task automatic test_parity_err();
        logic [63:0] v;
        ps2_frame(8'h1C, 1, 0, 0);
        model_frame(8'h1C, 1);
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL parity_status: got %h expected %h", v, exp_status()); tests_failed++; end
        do_clear();
        rd(SA, v);
        tests_run++;
        if (v !== 64'h10000) begin $display("FAIL parity_clear: got %h expected %h", v, 64'h10000); tests_failed++; end
    endtask

    task automatic test_overflow();
        logic [63:0] v;
        for (int i = 1; i <= 5; i++) begin
            ps2_frame(8'(i), 0, 0, 0);
            model_frame(8'(i), 0);
        end
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL ovf_status: got %h expected %h", v, exp_status()); tests_failed++; end
        for (int i = 1; i <= 4; i++) begin
            rd(DA, v);
            tests_run++;
            if (v !== 64'(i)) begin $display("FAIL ovf_order%0d: got %h expected %h", i, v, 64'(i)); tests_failed++; end
            do_pop();
            model_pop();
        end
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL ovf_drained: got %h expected %h", v, exp_status()); tests_failed++; end
        do_clear();
    endtask

    task automatic test_timeout();
        logic [63:0] v;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        PS2_data = 1'b1;
        repeat (1200) @(negedge system_clk);
        m_ferr = 1'b1;
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL timeout_status: got %h expected %h", v, exp_status()); tests_failed++; end
        ps2_frame(8'hF0, 0, 0, 0);
        model_frame(8'hF0, 0);
        rd(DA, v);
        tests_run++;
        if (v !== 64'hF0) begin $display("FAIL timeout_next: got %h expected f0", v); tests_failed++; end
        do_pop();
        model_pop();
        do_clear();
    endtask

    task automatic test_full_simul_pop();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            ps2_frame(8'hA0 + 8'(i), 0, 0, 0);
            model_frame(8'hA0 + 8'(i), 0);
        end
        ps2_frame(8'hA4, 0, 0, 1);
        model_pop();
        model_frame(8'hA4, 0);
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL simul_status: got %h expected %h", v, exp_status()); tests_failed++; end
        for (int i = 1; i <= 4; i++) begin
            rd(DA, v);
            tests_run++;
            if (v !== 64'(8'hA0 + 8'(i))) begin $display("FAIL simul_order%0d: got %h expected %h", i, v, 64'(8'hA0 + 8'(i))); tests_failed++; end
            do_pop();
            model_pop();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] v;
        ps2_frame(8'h11, 0, 0, 0);
        model_frame(8'h11, 0);
        ps2_frame(8'h22, 0, 0, 0);
        model_frame(8'h22, 0);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        reset = 1'b0;
        model_q.delete();
        m_perr = 0; m_ferr = 0; m_ovf = 0;
        rd(SA, v);
        tests_run++;
        if (irq !== 1'b0) begin $display("FAIL midreset_irq: got %b expected 0", irq); tests_failed++; end
        tests_run++;
        if (v !== 64'h10000) begin $display("FAIL midreset_status: got %h expected %h", v, 64'h10000); tests_failed++; end
        @(negedge system_clk);
        reset = 1'b1;
        @(negedge system_clk);
        ps2_frame(8'h29, 0, 0, 0);
        model_frame(8'h29, 0);
        rd(SA, v);
        tests_run++;
        if (v !== exp_status()) begin $display("FAIL midreset_after_status: got %h expected %h", v, exp_status()); tests_failed++; end
        rd(DA, v);
        tests_run++;
        if (v !== 64'h29) begin $display("FAIL midreset_after_data: got %h expected 29", v); tests_failed++; end
    endtask

    task automatic test_random();
        logic [63:0] v;
        logic [7:0]  b;
        int          kind, r;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                do_pop();
                model_pop();
            end
            if ($urandom_range(0, 9) < 2) do_clear();
            b = 8'($urandom());
            r = int'($urandom_range(0, 9));
            kind = (r < 7) ? 0 : (r < 9) ? 1 : 2;
            ps2_frame(b, kind == 1, kind == 2, 0);
            model_frame(b, kind);
            rd(SA, v);
            tests_run++;
            if (v !== exp_status()) begin $display("FAIL rand_status[%0d]: got %h expected %h", n, v, exp_status()); tests_failed++; end
            rd(DA, v);
            tests_run++;
            if (v !== exp_head()) begin $display("FAIL rand_head[%0d]: got %h expected %h", n, v, exp_head()); tests_failed++; end
        end
    endtask

    initial begin
        repeat (3) @(negedge system_clk);
        test_reset();
        test_single_frame();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_full_simul_pop();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
